// File: rtl/io_arb_pkg.sv
// io_arb_pkg: shared constants for the IO/UART arbitration slice
package io_arb_pkg;
   localparam int UART_DEPTH_DEF = 8;
   localparam int IO_BUSY_BIT    = 9;
   localparam int IO_UART_WORD   = 1;
   localparam int IO_STATUS_WORD = 2;
   localparam int IO_HALT_WORD   = 3;
   function automatic logic [1:0] accept_cnt(input logic [1:0] n_req, input int unsigned free);
      return (free >= 32'(n_req)) ? n_req : free[1:0];
   endfunction
endpackage

// File: rtl/fifo_2w1r.sv
// fifo_2w1r: byte FIFO with two write ports (push1 only alongside push0) and one show-ahead read port
module fifo_2w1r #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push0,
   input  logic [7:0]               d0,
   input  logic                     push1,
   input  logic [7:0]               d1,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   // storage writes; the older byte lands at wr_ptr, the younger one right after it
   always_ff @(posedge clk) begin
      if (push0) mem[wr_ptr] <= d0;
      if (push1) mem[wr_ptr + AW'(1)] <= d1;
   end
   // pointers wrap modulo DEPTH; count carries the extra bit to tell full from empty
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
      end
   end
   assign head = mem[rd_ptr];
endmodule

// File: rtl/uart_io_arbiter.sv
// uart_io_arbiter: merges slot A/B UART writes into one FIFO feeding the shared byte UART
module uart_io_arbiter
   import io_arb_pkg::*;
#(
   parameter int DEPTH = UART_DEPTH_DEF,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_valid,
   input  logic [7:0]       a_data,
   input  logic             b_valid,
   input  logic [7:0]       b_data,
   output logic             uart_valid,
   output logic [7:0]       uart_data,
   input  logic             uart_ready,
   output logic             busy,
   output logic             empty,
   output logic             overflow,
   input  logic             clr_overflow,
   output logic [CNT_W-1:0] drop_cnt
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic [CW-1:0]  count, free;
   logic [1:0]     n_req, n_acc, n_drop;
   logic           push0, push1, pop;
   logic [7:0]     d0;
   logic [CNT_W:0] cnt_sum;
   // space is judged on registered count only, so a same-cycle pop never frees room for a push
   assign free    = CW'(DEPTH) - count;
   assign n_req   = {1'b0, a_valid} + {1'b0, b_valid};
   assign n_acc   = accept_cnt(n_req, 32'(free));
   assign n_drop  = n_req - n_acc;
   assign push0   = n_acc != 2'd0;
   assign push1   = n_acc == 2'd2;
   assign d0      = a_valid ? a_data : b_data;
   assign pop     = uart_valid & uart_ready;
   assign cnt_sum = {1'b0, drop_cnt} + (CNT_W+1)'(n_drop);
   fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push0 (push0),
      .d0    (d0),
      .push1 (push1),
      .d1    (b_data),
      .pop   (pop),
      .head  (uart_data),
      .count (count)
   );
   assign uart_valid = count != '0;
   assign empty      = count == '0;
   assign busy       = count > CW'(DEPTH - 2);
   // sticky overflow and saturating drop counter; a clear discards that cycle's drops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (clr_overflow) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (n_drop != 2'd0) begin
         overflow <= 1'b1;
         drop_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      end
   end
endmodule

// File: tb/tb_uart_io_arbiter.sv
// tb_uart_io_arbiter: directed and random checks of uart_io_arbiter against a queue model
module tb_uart_io_arbiter;
   localparam int DEPTH = 8;
   logic       clk = 0, reset = 1;
   logic       a_valid = 0, b_valid = 0, uart_ready = 0, clr_overflow = 0;
   logic [7:0] a_data = 0, b_data = 0;
   logic       uart_valid, busy, empty, overflow;
   logic [7:0] uart_data, drop_cnt;
   int total = 0, bad = 0;
   byte unsigned q[$];
   bit m_ovf = 0;
   int m_cnt = 0;
   uart_io_arbiter #(.DEPTH(DEPTH), .CNT_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .a_valid      (a_valid),
      .a_data       (a_data),
      .b_valid      (b_valid),
      .b_data       (b_data),
      .uart_valid   (uart_valid),
      .uart_data    (uart_data),
      .uart_ready   (uart_ready),
      .busy         (busy),
      .empty        (empty),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .drop_cnt     (drop_cnt)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic check_all();
      chk("uart_valid", 32'(uart_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("uart_data", 32'(uart_data), 32'(q[0]));
      chk("busy", 32'(busy), 32'(q.size() > DEPTH - 2));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
   endtask
   task automatic step(input bit av, input byte unsigned ad, input bit bv, input byte unsigned bd,
                       input bit rdy, input bit clr);
      int fr, drp;
      a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
      uart_ready = rdy; clr_overflow = clr;
      @(posedge clk);
      fr  = DEPTH - q.size();
      drp = 0;
      if (rdy && q.size() != 0) void'(q.pop_front());
      if (av) begin
         if (fr > 0) begin q.push_back(ad); fr--; end else drp++;
      end
      if (bv) begin
         if (fr > 0) q.push_back(bd); else drp++;
      end
      if (clr) begin
         m_ovf = 0; m_cnt = 0;
      end else if (drp != 0) begin
         m_ovf = 1; m_cnt = (m_cnt + drp > 255) ? 255 : m_cnt + drp;
      end
      @(negedge clk);
      check_all();
   endtask
   task automatic do_reset();
      a_valid = 0; b_valid = 0; uart_ready = 0; clr_overflow = 0;
      reset = 1;
      #1;
      chk("rst_uart_valid", 32'(uart_valid), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_drop_cnt", 32'(drop_cnt), 0);
      q.delete(); m_ovf = 0; m_cnt = 0;
      @(negedge clk);
      reset = 0;
   endtask
   initial begin
      #2;
      do_reset();
      step(1, 8'h41, 0, 0, 1, 0);
      chk("single_head", 32'(uart_data), 32'h41);
      step(0, 0, 0, 0, 1, 0);
      chk("single_empty", 32'(empty), 1);
      step(1, 8'h48, 1, 8'h49, 1, 0);
      chk("dual_first", 32'(uart_data), 32'h48);
      step(0, 0, 0, 0, 1, 0);
      chk("dual_second", 32'(uart_data), 32'h49);
      step(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) step(1, byte'(8'h30 + i), 0, 0, 0, 0);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_head", 32'(uart_data), 32'h30);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 7; i++) step(1, byte'(8'h50 + i), 0, 0, 0, 0);
      step(1, 8'hAA, 1, 8'hBB, 0, 0);
      chk("nf_overflow", 32'(overflow), 1);
      chk("nf_drop_cnt", 32'(drop_cnt), 1);
      step(0, 0, 0, 0, 0, 1);
      chk("clr_overflow", 32'(overflow), 0);
      step(1, 8'hAB, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      step(1, 8'hCC, 0, 0, 1, 0);
      chk("full_pop_drop", 32'(drop_cnt), 1);
      chk("full_pop_busy", 32'(busy), 1);
      step(1, 8'hDD, 0, 0, 0, 1);
      chk("clr_wins", 32'(overflow), 0);
      do_reset();
      for (int i = 0; i < 5; i++) step(1, byte'(8'h60 + i), 0, 0, 0, 0);
      do_reset();
      step(1, 8'h77, 0, 0, 0, 0);
      chk("post_rst_head", 32'(uart_data), 32'h77);
      for (int i = 0; i < 150; i++) step(1, byte'($urandom), 1, byte'($urandom), 0, 0);
      chk("sat_drop_cnt", 32'(drop_cnt), 32'hFF);
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3000; i++) begin
         int ph;
         ph = (i / 250) % 3;
         if ($urandom_range(0, 299) == 0) do_reset();
         else step($urandom_range(0, 1) == 1, byte'($urandom), $urandom_range(0, 2) == 0, byte'($urandom),
                   ph == 0 ? $urandom_range(0, 3) != 0 : ph == 1 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 1) == 1,
                   $urandom_range(0, 40) == 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_io_arbiter.md
# uart_io_arbiter

Merges the two IO write ports of the dual-issue core (slot A, slot B) onto the single shared byte UART, so both slots' writes to the UART word are delivered and neither is lost to a blind OR. A small dual-push / single-pop FIFO absorbs bursts. The block sits between the core's IO decode (`a_uart_valid`, `b_uart_valid`) and `corescore_emitter_uart`. It also provides the busy bit that software polls through the IO status word.

## Interface
Parameters:
- `DEPTH`, 8: FIFO capacity in bytes; power of two, ≥ 4.
- `CNT_W`, 8: width of the drop counter.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `a_valid`  in  1  slot A UART write strobe (one cycle per byte).
- `a_data`  in  8  slot A byte.
- `b_valid`  in  1  slot B UART write strobe.
- `b_data`  in  8  slot B byte.
- `uart_valid`  out  1  byte available to the UART.
- `uart_data`  out  8  head byte.
- `uart_ready`  in  1  UART accepts the byte.
- `busy`  out  1  fewer than 2 free slots; drives IO status bit 9.
- `empty`  out  1  FIFO empty and no transfer pending; used for halt drain.
- `overflow`  out  1  sticky; set when any byte is dropped.
- `clr_overflow`  in  1  clears `overflow` and `drop_cnt`.
- `drop_cnt`  out  `CNT_W`  saturating count of dropped bytes.

## Operation
- Ordering:
  - Slot A is the older instruction.
  - When A and B are valid in the same cycle, A is written at `wr_ptr` and B at `wr_ptr+1`.
  - When only one slot is valid, that byte takes one slot.
- Space check:
  - `free = DEPTH - count`, evaluated on the registered `count` before this cycle's pop.
  - A pop in the same cycle gives no credit to pushes.
- Drop rules:
  - If `free == 1` and both slots are valid, A is accepted and B is dropped.
  - If `free == 0`, every valid byte is dropped.
  - Each dropped byte increments `drop_cnt`, which saturates at all-ones, and sets `overflow`.
- Pop:
  - A pop occurs when `uart_valid & uart_ready`.
  - `rd_ptr` advances by 1 and `count` decrements.
- Count update: `count_next = count + pushes(0..2) - pop(0..1)`.
- Pointer arithmetic:
  - Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
  - `count` is `$clog2(DEPTH)+1` bits.
- Output behaviour:
  - `uart_valid = (count != 0)`.
  - `uart_data = mem[rd_ptr]` (show-ahead).
  - `uart_data` is held stable while `uart_valid & !uart_ready`.
- Status outputs:
  - `busy = (count > DEPTH-2)`. Software that waits for `!busy` before each write can never drop a byte, even when both slots write together.
  - `empty = (count == 0)`.
- Clear vs. drop: `clr_overflow` in the same cycle as a drop clears the flag and counter, and that cycle's drop is not recorded (clear wins).
- Reset values: `count=0`, `wr_ptr=0`, `rd_ptr=0`, `overflow=0`, `drop_cnt=0`. Therefore `uart_valid=0`, `busy=0`, `empty=1`. `uart_data` is don't-care (memory is not reset).
- Reset mid-transfer: all queued bytes are discarded. A byte that the UART has already accepted is not affected.

## Timing
- Latency:
  - A byte pushed in cycle N into an empty FIFO appears with `uart_valid=1` in cycle N+1.
  - A and B pushed together in cycle N: A is presented from N+1; B is presented in the cycle after A's handshake.
- Throughput: at most one pop per cycle. Two pushes plus one pop in one cycle net +1.
- Flag timing: `busy`, `empty`, `overflow` and `drop_cnt` are registered-state functions and update the cycle after the causing edge.
- State machine:
  - No explicit FSM. State is the `{count, wr_ptr, rd_ptr}` register set plus the sticky flag.
  - Implicit states are EMPTY (count=0), PARTIAL, NEARFULL (count=DEPTH-1) and FULL (count=DEPTH).

## Structure
- Package `io_arb_pkg` holds:
  - `UART_DEPTH_DEF = 8`
  - `IO_BUSY_BIT = 9`
  - `IO_UART_WORD = 1`, `IO_STATUS_WORD = 2`, `IO_HALT_WORD = 3` (word-address bit indices).
- Sub-module `fifo_2w1r`: storage, pointers and count, with push0/push1/pop ports.
- The top level owns the arbitration, drop logic, flags and counter.

## Test plan
- Single byte: A writes `0x41` into an idle FIFO with `uart_ready=1` → `uart_valid` in the next cycle with `0x41`; one pop; `empty=1` two cycles after the push.
- Dual push: A=`0x48`, B=`0x49` in the same cycle → UART receives `0x48` then `0x49`, in that order; `count` peaks at 2.
- Backpressure: hold `uart_ready=0` and push 8 bytes `0x30`..`0x37` → `busy=1` after count reaches 7; `uart_data` stays `0x30`; releasing ready drains all 8 bytes in order.
- Overflow at NEARFULL: count=7, A=`0xAA` and B=`0xBB` together → `0xAA` accepted, `0xBB` dropped, `overflow=1`, `drop_cnt=1`; `clr_overflow` returns both to 0.
- Full with simultaneous pop: count=8, `uart_ready=1`, A valid → A dropped (no pop credit), count becomes 7, `drop_cnt` increments.
- Reset mid-stream: assert `reset` with 5 bytes queued → immediately `uart_valid=0`, `empty=1`, `drop_cnt=0`; the next push behaves as from idle.
